// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with runtime-loadable pattern, length and overlap mode.
// Optional saturating match counter is built when SEQ_DETECT_PROG_CNT_EN is defined.
module seq_detect_prog #(
  parameter int              PAT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 8'h0F,
  parameter int              DEF_LEN     = 4,
  parameter logic            DEF_OVERLAP = 1'b1,
  parameter int              CNT_W       = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_valid,
  input  logic                         i_data,
  input  logic                         i_cfg_load,
  input  logic [PAT_W-1:0]             i_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   i_pat_len,
  input  logic                         i_overlap,
  output logic                         o_detect,
  output logic                         o_cfg_err,
  output logic [CNT_W-1:0]             o_count
);

  localparam int LEN_W = $clog2(PAT_W+1);

  logic [PAT_W-2:0] hist_r;
  logic [LEN_W-1:0] fill_r;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic             detect_r;
  logic             cfg_err_r;

  logic [PAT_W-1:0] shifted_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W:0]   fill_inc_s;
  logic [LEN_W-1:0] fill_next_s;
  logic             match_s;
  logic             len_ok_s;

  assign shifted_s   = {hist_r, i_data};
  assign fill_inc_s  = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
  assign fill_next_s = (fill_r == LEN_W'(PAT_W)) ? fill_r : fill_inc_s[LEN_W-1:0];
  assign len_ok_s    = (i_pat_len != {LEN_W{1'b0}}) && (i_pat_len <= LEN_W'(PAT_W));

  // Select the low len_r bits of the window; bits above len-1 never take part.
  always_comb begin
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
  end

  assign match_s = (fill_inc_s >= {1'b0, len_r}) &&
                   (((shifted_s ^ pat_r) & mask_s) == {PAT_W{1'b0}});

  // Configuration, history, fill and flag registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hist_r    <= {(PAT_W-1){1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      pat_r     <= DEF_PATTERN;
      len_r     <= LEN_W'(DEF_LEN);
      ovl_r     <= DEF_OVERLAP;
      detect_r  <= 1'b0;
      cfg_err_r <= 1'b0;
    end else if (i_cfg_load) begin
      hist_r    <= {(PAT_W-1){1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      detect_r  <= 1'b0;
      cfg_err_r <= !len_ok_s;
      if (len_ok_s) begin
        pat_r <= i_pattern;
        len_r <= i_pat_len;
        ovl_r <= i_overlap;
      end
    end else if (i_valid) begin
      hist_r    <= shifted_s[PAT_W-2:0];
      detect_r  <= match_s;
      cfg_err_r <= 1'b0;
      // Non-overlapping mode demands len fresh bits after every hit.
      fill_r    <= (match_s && !ovl_r) ? {LEN_W{1'b0}} : fill_next_s;
    end else begin
      detect_r  <= 1'b0;
      cfg_err_r <= 1'b0;
    end
  end

  assign o_detect  = detect_r;
  assign o_cfg_err = cfg_err_r;

`ifdef SEQ_DETECT_PROG_CNT_EN
  logic [CNT_W-1:0] count_r;

  // Saturating count of edges that raise o_detect.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_r <= {CNT_W{1'b0}};
    end else if (i_cfg_load) begin
      count_r <= {CNT_W{1'b0}};
    end else if (i_valid && match_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = count_r;
`else
  assign o_count = {CNT_W{1'b0}};
`endif

endmodule
